// File: rtl/data_path_gen2.sv
// CPU data path: PC/MAR/IR/CCR/MDR/SP registers, BUS1/BUS2 muxing and a req/ack memory port with timeout.
// Memory access takes at least 2 cycles (start + ack); new requests while busy are dropped, not queued.
module data_path_gen2 #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 8,
  parameter int                 FLAG_W   = 4,
  parameter logic [ADDR_W-1:0]  SP_TOP   = ADDR_W'('hFF),
  parameter logic [ADDR_W-1:0]  SP_LIMIT = ADDR_W'('hE0),
  parameter int                 MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ir_load,
  input  logic              mar_load,
  input  logic              pc_load,
  input  logic              pc_rel,
  input  logic              pc_inc,
  input  logic              ccr_load,
  input  logic              sp_dec,
  input  logic              sp_inc,
  input  logic [1:0]        bus1_sel,
  input  logic [2:0]        bus2_sel,
  input  logic [1:0]        addr_sel,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] from_memory,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  input  logic [DATA_W-1:0] imm,
  input  logic [ADDR_W-1:0] addr_val,
  input  logic [FLAG_W-1:0] nzvc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] to_memory,
  output logic [DATA_W-1:0] ir,
  output logic [FLAG_W-1:0] ccr,
  output logic [DATA_W-1:0] bus2_data,
  output logic              busy,
  output logic              bus_err,
  output logic              stack_err
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc, r_mar, r_sp, r_addr;
  logic [DATA_W-1:0] r_ir, r_mdr, r_wdat;
  logic [FLAG_W-1:0] r_ccr;
  logic [WAIT_W-1:0] r_wait;
  logic              r_mem_req, r_mem_we, r_busy, r_bus_err, r_stack_err;

  logic [DATA_W-1:0] w_bus1, w_bus2;
  logic [ADDR_W-1:0] w_addr_mux, w_bus2_zext, w_bus2_sext;

  always_comb begin
    w_bus1 = '0;
    case (bus1_sel)
      2'd0:    w_bus1 = DATA_W'(r_pc);
      2'd1:    w_bus1 = reg_a;
      2'd2:    w_bus1 = reg_b;
      default: w_bus1 = DATA_W'(r_sp);
    endcase
  end

  always_comb begin
    w_bus2 = '0;
    case (bus2_sel)
      3'd0:    w_bus2 = alu_result;
      3'd1:    w_bus2 = w_bus1;
      3'd2:    w_bus2 = r_mdr;
      3'd3:    w_bus2 = imm;
      3'd4:    w_bus2 = DATA_W'(addr_val);
      default: w_bus2 = '0;
    endcase
  end

  always_comb begin
    w_addr_mux = r_pc;
    case (addr_sel)
      2'd1:    w_addr_mux = r_mar;
      2'd2:    w_addr_mux = r_sp;
      default: w_addr_mux = r_pc;
    endcase
  end

  assign w_bus2_zext = ADDR_W'(w_bus2);
  assign w_bus2_sext = ADDR_W'($signed(w_bus2));

  // Architectural registers follow their strobes every cycle, independent of the memory FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_ccr       <= '0;
      r_sp        <= SP_TOP;
      r_stack_err <= 1'b0;
    end else begin
      if (ir_load)  r_ir  <= w_bus2;
      if (mar_load) r_mar <= ADDR_W'(w_bus2);
      if (ccr_load) r_ccr <= nzvc;
      if (pc_load)      r_pc <= w_bus2_zext;
      else if (pc_rel)  r_pc <= r_pc + w_bus2_sext;
      else if (pc_inc)  r_pc <= r_pc + ADDR_W'(1);
      case ({sp_dec, sp_inc})
        2'b10: if (r_sp == SP_LIMIT) r_stack_err <= 1'b1;
               else                  r_sp <= r_sp - ADDR_W'(1);
        2'b01: if (r_sp == SP_TOP)   r_stack_err <= 1'b1;
               else                  r_sp <= r_sp + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdat    <= '0;
      r_mdr     <= '0;
      r_wait    <= '0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_busy    <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_rd || mem_wr) begin
            r_state   <= S_ACCESS;
            r_addr    <= w_addr_mux;
            r_wdat    <= w_bus1;
            r_wait    <= '0;
            r_mem_req <= 1'b1;
            r_mem_we  <= mem_wr;
            r_busy    <= 1'b1;
          end
        end
        S_ACCESS: begin
          // An ack arriving in the final wait cycle still completes the access.
          if (mem_ack) begin
            if (!r_mem_we) r_mdr <= from_memory;
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_busy    <= 1'b0;
          end else if (r_wait == WAIT_LAST) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_busy    <= 1'b0;
            r_bus_err <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign address   = r_busy ? r_addr : w_addr_mux;
  assign to_memory = r_wdat;
  assign ir        = r_ir;
  assign ccr       = r_ccr;
  assign bus2_data = w_bus2;
  assign busy      = r_busy;
  assign bus_err   = r_bus_err;
  assign stack_err = r_stack_err;

endmodule

// File: tb/tb_data_path_gen2.sv
// Directed self-checking bench for data_path_gen2 with hand-computed expectations.
module tb_data_path_gen2;

  logic       clk = 1'b0;
  logic       reset;
  logic       ir_load, mar_load, pc_load, pc_rel, pc_inc, ccr_load, sp_dec, sp_inc;
  logic [1:0] bus1_sel, addr_sel;
  logic [2:0] bus2_sel;
  logic       mem_rd, mem_wr, mem_ack;
  logic [7:0] from_memory, alu_result, reg_a, reg_b, imm, addr_val;
  logic [3:0] nzvc;
  logic       mem_req, mem_we, busy, bus_err, stack_err;
  logic [7:0] address, to_memory, ir, bus2_data;
  logic [3:0] ccr;

  int checks = 0;
  int failures = 0;
  int n;

  data_path_gen2 dut (
    .clk(clk), .reset(reset),
    .ir_load(ir_load), .mar_load(mar_load), .pc_load(pc_load), .pc_rel(pc_rel),
    .pc_inc(pc_inc), .ccr_load(ccr_load), .sp_dec(sp_dec), .sp_inc(sp_inc),
    .bus1_sel(bus1_sel), .bus2_sel(bus2_sel), .addr_sel(addr_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack), .from_memory(from_memory),
    .alu_result(alu_result), .reg_a(reg_a), .reg_b(reg_b), .imm(imm),
    .addr_val(addr_val), .nzvc(nzvc),
    .mem_req(mem_req), .mem_we(mem_we), .address(address), .to_memory(to_memory),
    .ir(ir), .ccr(ccr), .bus2_data(bus2_data), .busy(busy),
    .bus_err(bus_err), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Route a register onto BUS2 through BUS1 and let it settle.
  task automatic peek_bus1(input logic [1:0] sel);
    bus1_sel = sel;
    bus2_sel = 3'd1;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    {ir_load, mar_load, pc_load, pc_rel, pc_inc, ccr_load, sp_dec, sp_inc} = '0;
    bus1_sel = '0; bus2_sel = '0; addr_sel = '0;
    {mem_rd, mem_wr, mem_ack} = '0;
    from_memory = '0; alu_result = '0; reg_a = '0; reg_b = '0; imm = '0; addr_val = '0;
    nzvc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;

    peek_bus1(2'd0);  check("reset_pc", bus2_data, 8'h00);
    peek_bus1(2'd3);  check("reset_sp", bus2_data, 8'hFF);
    check("reset_req", {mem_req, mem_we, busy, bus_err, stack_err}, 5'b0);
    check("reset_ir_ccr", {ir, ccr}, 12'h000);

    // Read at PC with three wait cycles before ack
    addr_sel = 2'd0;
    mem_rd = 1'b1; tick(); mem_rd = 1'b0;
    check("rd_start", {mem_req, mem_we, address}, {1'b1, 1'b0, 8'h00});
    n = 0;
    repeat (3) begin
      if (busy) n++;
      tick();
    end
    from_memory = 8'hA5; mem_ack = 1'b1;
    if (busy) n++;
    tick();
    mem_ack = 1'b0;
    check("rd_busy_cycles", n, 4);
    check("rd_done", {mem_req, busy}, 2'b00);
    bus2_sel = 3'd2; #1;
    check("rd_mdr", bus2_data, 8'hA5);

    // PC-relative branch backwards and wrap-around
    bus2_sel = 3'd3; imm = 8'h10; pc_load = 1'b1; tick(); pc_load = 1'b0;
    imm = 8'hFC; pc_rel = 1'b1; tick(); pc_rel = 1'b0;
    peek_bus1(2'd0);  check("pc_rel_neg", bus2_data, 8'h0C);
    bus2_sel = 3'd3; imm = 8'hFF; pc_load = 1'b1; tick(); pc_load = 1'b0;
    pc_inc = 1'b1; tick(); pc_inc = 1'b0;
    peek_bus1(2'd0);  check("pc_inc_wrap", bus2_data, 8'h00);
    bus2_sel = 3'd3; imm = 8'h40; pc_load = 1'b1; pc_inc = 1'b1; tick();
    pc_load = 1'b0;
    imm = 8'h02; pc_rel = 1'b1; tick(); pc_rel = 1'b0; pc_inc = 1'b0;
    peek_bus1(2'd0);  check("pc_load_over_inc_then_rel", bus2_data, 8'h42);

    // IR, CCR, MAR loads
    bus2_sel = 3'd0; alu_result = 8'h3C; ir_load = 1'b1;
    nzvc = 4'hA; ccr_load = 1'b1; tick();
    ir_load = 1'b0; ccr_load = 1'b0;
    check("ir_ccr_load", {ir, ccr}, {8'h3C, 4'hA});
    bus2_sel = 3'd4; addr_val = 8'h77; mar_load = 1'b1; tick(); mar_load = 1'b0;

    // Write with no ack: timeout, with a mem_rd dropped mid-access
    addr_sel = 2'd1; bus1_sel = 2'd1; reg_a = 8'h5A;
    mem_wr = 1'b1; tick(); mem_wr = 1'b0;
    reg_a = 8'h11; addr_sel = 2'd0;
    #1;
    check("wr_start", {mem_req, mem_we, address, to_memory}, {1'b1, 1'b1, 8'h77, 8'h5A});
    n = 1;
    mem_rd = 1'b1; tick(); mem_rd = 1'b0;
    check("rd_ignored_while_busy", {mem_we, address}, {1'b1, 8'h77});
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
    check("wr_timeout_cycles", n, 15);
    check("wr_timeout_err", {mem_req, busy, bus_err}, 3'b001);
    tick();
    check("no_queued_access", mem_req, 1'b0);
    from_memory = 8'h99; mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    bus2_sel = 3'd2; #1;
    check("mdr_kept_after_timeout_and_idle_ack", {busy, bus2_data}, {1'b0, 8'hA5});

    // Stack pointer limits
    sp_dec = 1'b1; tick();
    sp_inc = 1'b1; tick(); sp_inc = 1'b0;
    peek_bus1(2'd3);  check("sp_dec_and_noop", bus2_data, 8'hFE);
    repeat (30) tick();
    sp_dec = 1'b0;
    peek_bus1(2'd3);  check("sp_at_limit", {stack_err, bus2_data}, {1'b0, 8'hE0});
    sp_dec = 1'b1; tick(); sp_dec = 1'b0;
    peek_bus1(2'd3);  check("sp_underflow", {stack_err, bus2_data}, {1'b1, 8'hE0});

    // Reset in the middle of an access
    mem_rd = 1'b1; tick(); mem_rd = 1'b0;
    check("rd2_start", mem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_req", {mem_req, busy, bus_err, stack_err}, 4'b0000);
    peek_bus1(2'd3);  check("async_reset_sp", bus2_data, 8'hFF);
    tick();
    reset = 1'b1;
    tick();
    check("post_reset_idle", {mem_req, busy}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
